// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: core (C) priority,
// bounded starvation for the DMA/debug port (D), exclusive D lock, alignment check.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CORE, DMA, LOCK} state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t            state_reg, state_next;
  logic [3:0]        hold_cnt_reg, hold_cnt_next;
  logic              lock_hold;
  logic [1:0]        req, we, gnt, aligned;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];

  // Index 0 is the core port, index 1 the DMA port.
  assign req      = {d_req, c_req};
  assign we       = {d_we, c_we};
  assign addr[0]  = c_addr;
  assign addr[1]  = d_addr;
  assign wdata[0] = c_wdata;
  assign wdata[1] = d_wdata;

  assign lock_hold = (state_reg == LOCK) && d_lock;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // LOCK is kept while d_lock stays high even through idle D cycles, so the
  // core cannot slip in between the accesses of an atomic loader sequence.
  always_comb begin
    gnt           = 2'b00;
    state_next    = IDLE;
    hold_cnt_next = '0;
    if (rst) begin
      if (lock_hold) begin
        gnt[1] = d_req;
      end else if (c_req && d_req) begin
        if (hold_cnt_reg >= MAX_HOLD_C) gnt[1] = 1'b1;
        else                            gnt[0] = 1'b1;
      end else begin
        gnt = req;
      end
    end
    if ((gnt[1] && d_lock) || lock_hold) state_next = LOCK;
    else if (gnt[0])                     state_next = CORE;
    else if (gnt[1])                     state_next = DMA;
    if (gnt[0] && d_req)
      hold_cnt_next = (hold_cnt_reg == 4'hF) ? 4'hF : hold_cnt_reg + 4'd1;
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_write = c_we & aligned[0];
      mem_read  = ~c_we & aligned[0];
    end else if (gnt[1]) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_write = d_we & aligned[1];
      mem_read  = ~d_we & aligned[1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic              rvalid_reg;
      logic              err_reg;
      logic [DATA_W-1:0] rdata_reg;

      assign aligned[gi] = (addr[gi][1:0] == 2'b00);

      // Misaligned accesses answer with an error for loads and stores alike;
      // aligned stores complete at the grant and produce no response.
      always_ff @(posedge clk) begin
        if (!rst) begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          rdata_reg  <= '0;
        end else if (gnt[gi] && !aligned[gi]) begin
          rvalid_reg <= 1'b1;
          err_reg    <= 1'b1;
          rdata_reg  <= '0;
        end else if (gnt[gi] && !we[gi]) begin
          rvalid_reg <= 1'b1;
          err_reg    <= 1'b0;
          rdata_reg  <= mem_rdata;
        end else begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
        end
      end
    end
  endgenerate

  // Responses are masked while reset is held so an in-flight access is dropped.
  assign c_gnt    = gnt[0];
  assign d_gnt    = gnt[1];
  assign c_stall  = c_req & ~gnt[0];
  assign c_rvalid = g_resp[0].rvalid_reg & rst;
  assign c_err    = g_resp[0].err_reg & rst;
  assign c_rdata  = g_resp[0].rdata_reg;
  assign d_rvalid = g_resp[1].rvalid_reg & rst;
  assign d_err    = g_resp[1].err_reg & rst;
  assign d_rdata  = g_resp[1].rdata_reg;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the core load/store path (port C) and a debug/DMA loader (port D).
- Sits between the core datapath and data memory. Generates a stall to freeze the PC and register writeback while a core access waits.
- Arbitration is core-priority, with a starvation bound for D and an exclusive lock mode for atomic loader sequences.
- Rejects misaligned accesses before they reach memory.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_HOLD, 4, maximum consecutive C grants while D is waiting; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- c_req  in  1  core access request; held with its payload until c_gnt.
- c_we  in  1  core write enable (1 = store, 0 = load).
- c_addr  in  ADDR_W  core byte address.
- c_wdata  in  DATA_W  core store data.
- c_gnt  out  1  core access accepted this cycle.
- c_rvalid  out  1  core load response valid (1-cycle pulse).
- c_rdata  out  DATA_W  core load data.
- c_err  out  1  core misaligned-access error, pulsed together with c_rvalid.
- c_stall  out  1  c_req & ~c_gnt; holds the core PC.
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  DMA request, same meaning as port C.
- d_lock  in  1  DMA exclusive-access request.
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DATA_W/1  DMA response, same meaning as port C.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe.
- mem_addr  out  ADDR_W  data memory address.
- mem_wdata  out  DATA_W  data memory write data.
- mem_rdata  in  DATA_W  data memory combinational read data.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, hold_cnt=0.
  - All registered outputs go to 0: c_rvalid, d_rvalid, c_err, d_err, c_rdata, d_rdata.
  - Any in-flight response is discarded; no rvalid is issued after reset.
  - While rst=0, c_gnt, d_gnt, mem_read and mem_write are forced to 0.
- States:
  - IDLE: no grant last cycle.
  - CORE: C granted last cycle.
  - DMA: D granted last cycle.
  - LOCK: D owns memory exclusively.
  - Next state: LOCK if d_gnt & d_lock; otherwise CORE, DMA or IDLE according to this cycle's grant.
- Grant decision (combinational from the req inputs, state and hold_cnt; at most one grant per cycle):
  - State LOCK with d_lock=1: only D may be granted; c_gnt=0 even when D is idle.
  - State LOCK with d_lock=0: leave LOCK; normal arbitration applies in that same cycle.
  - Only one request pending: grant it.
  - Both pending: grant D if hold_cnt>=MAX_HOLD, otherwise grant C.
- hold_cnt:
  - Increments (saturating at 15) on each cycle with c_gnt while d_req=1.
  - Clears to 0 on any cycle without c_gnt, and on any cycle with c_gnt and d_req=0.
  - Consequence: a waiting D is granted within MAX_HOLD+1 cycles.
- Memory drive:
  - mem_addr/mem_wdata mux from the granted port.
  - mem_write = gnt & we & aligned.
  - mem_read = gnt & ~we & aligned.
  - aligned = (addr[1:0]==0).
  - No grant: mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
- Misaligned access:
  - Still granted for one cycle, but no memory strobe is issued.
  - Next cycle: x_rvalid=1 and x_err=1 for both loads and stores, with x_rdata=0.
- Load response:
  - mem_rdata is registered at the grant edge into x_rdata.
  - x_rvalid=1 on the following cycle.
  - Latency is 1 cycle; x_rdata holds its value until the next load response.
- Store completion:
  - The store completes with gnt; no rvalid is issued.
  - Write data commits at the grant-cycle clock edge.
- Back-to-back: a new grant is allowed in the same cycle as the previous grant's rvalid, giving full throughput of 1 access per cycle.
- Requester rule: a requester must hold req and payload stable until gnt. The arbiter does not latch the payload.
- Reset mid-LOCK: the arbiter returns to IDLE, and D must reassert d_lock.

Test Plan:
- Reset, then c_req load at addr 0x10 with mem_rdata=0xDEADBEEF → c_gnt=1 and mem_read=1 the same cycle; next cycle c_rvalid=1, c_rdata=0xDEADBEEF, c_stall=0 throughout.
- c_req and d_req held continuously, MAX_HOLD=4 → grant sequence C,C,C,C,D,C,C,C,C,D…; c_stall=1 exactly in the D-grant cycles.
- D store with d_lock=1 to 0x20 (data 0x5), then core load of 0x20 requested while d_lock stays 1 for 3 cycles → c_gnt=0 and c_stall=1 for 3 cycles; after d_lock drops, C is granted in that same cycle and reads 0x5.
- c_req store to addr 0x13 → c_gnt=1 and mem_write=0; next cycle c_rvalid=1 and c_err=1; memory contents unchanged.
- Assert rst=0 in the cycle after a D load grant → d_rvalid stays 0; all outputs are 0 next cycle; state=IDLE and hold_cnt=0 once rst=1.
- Alternating C/D single loads with no contention → each granted the cycle requested; rvalid always exactly 1 cycle later, on the correct port only.
